bomb_countdown: RTL and testbench
=================================

# bomb_countdown

Countdown timer for the bomb game, directly downstream of the 1-second tick generator. It holds the remaining time as four BCD digits (MM:SS) and loads the preset time while the game is idle. It decrements once per 1-second tick while the game is running, and it applies wrong-move time penalties. When the time reaches 00:00 it raises a one-cycle time-out pulse that the game FSM consumes to enter the fail state; the digits also drive the 7-segment display driver.

## Interface
- P_INIT_MM, 8'h05, preset minutes as two BCD digits (00–99).
- P_INIT_SS, 8'h00, preset seconds as two BCD digits (00–59).
- P_WARN_SS, 8'h10, BCD seconds threshold for the warning; applies only when minutes = 00.
- P_PENALTY, 8'd10, seconds removed per penalty pulse (binary, 1–255).
- i_Clk  input  1  system clock, 50 MHz.
- i_Rst  input  1  asynchronous, active-low reset.
- i_State  input  3  game state: 000 idle, 001 game_start, 010 game_clear, 011 game_fail; 100–111 are treated as game_clear.
- i_Sec1Tick  input  1  one-cycle pulse once per second, only during game_start.
- i_Penalty  input  1  one-cycle pulse on a wrong player move.
- o_Min10, o_Min1, o_Sec10, o_Sec1  output  4 each  remaining time as BCD digits.
- o_TimeOut  output  1  one-cycle pulse when the time reaches 00:00.
- o_Warning  output  1  level; high in RUN while remaining time ≤ 00:P_WARN_SS.

## Operation
- Internal phases: IDLE, RUN, HOLD, EXPIRED.
- IDLE (i_State = 000): digits load the preset every cycle; pending is cleared.
- IDLE → RUN when i_State = 001.
- RUN → HOLD when i_State = 010/011/1xx.
- RUN → EXPIRED on reaching 00:00.
- HOLD and EXPIRED go to IDLE only when i_State = 000. A return to 001 from HOLD resumes RUN; EXPIRED ignores 001.
- Pending counter: 8-bit, counts seconds still to be removed.
  - dec = RUN & (i_Sec1Tick | pending ≠ 0) & (time ≠ 00:00).
  - pending_next = sat255(pending + (i_Penalty ? P_PENALTY : 0) + (i_Sec1Tick ? 1 : 0) − (dec ? 1 : 0)).
  - The counter only changes in RUN. It is cleared in IDLE, HOLD and EXPIRED, and on expiry.
- Decrementing one second, with borrows:
  - Sec1 0→9, borrowing from Sec10.
  - Sec10 0→5, borrowing from Min1.
  - Min1 0→9, borrowing from Min10.
  - Min10 decrements.
  - No decrement is ever applied at 00:00, so there is no underflow.
- Penalty: drains at one second per clock, so a penalty of 10 seconds takes 10 cycles to apply. A penalty larger than the remaining time stops at 00:00 and expires.
- Expiry: the cycle in which dec moves the time from 00:01 to 00:00 registers o_TimeOut = 1 for exactly one cycle, and the phase goes to EXPIRED.
- HOLD ignores i_Sec1Tick and i_Penalty; the digits freeze.

## Timing
- All outputs are registered.
- Reset values: digits = preset, o_TimeOut = 0, o_Warning = 0, phase IDLE, pending 0.
- A tick in cycle N (with pending = 0) shows the new digits in cycle N+1.
- A penalty pulse in cycle N starts its decrements at the end of cycle N+1 (it passes through pending first).
- o_TimeOut is high in the same cycle the digits first show 00:00.
- o_Warning is updated from the same registered digits and is valid one cycle after they change.
- Simultaneous events:
  - Tick and penalty in the same cycle: both are accumulated into pending.
  - Tick while pending ≠ 0: pending is unchanged.
  - i_State leaving 001 in the same cycle as a tick: the tick is ignored.
- Reset asserted mid-countdown forces the reset values immediately, asynchronously.

## Structure
- Shared package (shared with the game FSM and the tick generator): the 3-bit game-state codes, the phase encoding, and BCD digit width constants.
- Sub-module bcd_digit_down: one 4-bit digit with a parameterised wrap value (9 or 5), a load input, a dec-enable input, and a borrow-out signal that is high when the digit is 0 and dec is enabled. Instantiate it four times, chained through the borrows.

## Test plan
- Preset 00:12, reset, then i_State = 001 and 12 ticks → digits go 00:11 … 00:00; o_TimeOut high one cycle with the 00:00 display; later ticks leave 00:00.
- Preset 01:00, one tick → 00:59, which checks the borrow across all digits; with P_WARN_SS = 10, o_Warning rises at 00:10.
- Preset 00:30 in RUN, i_Penalty pulse → 10 consecutive decrements to 00:20. A tick arriving during the drain brings the final value to 00:19.
- Preset 00:05, penalty of 10 → stops at 00:00 with a single o_TimeOut pulse; pending reads 0 afterwards.
- RUN at 00:40, i_State = 010 for 5 ticks → digits stay 00:40; i_State = 000 reloads the preset; i_State = 001 then resumes counting down from the preset.
- Reset asserted at 00:07 mid-drain → digits = preset, o_TimeOut = 0, pending = 0, in the same cycle (asynchronously).

Source files
------------

// File: rtl/bomb_countdown_pkg.sv
// bomb_countdown_pkg: game-state codes, countdown phases and BCD constants shared across the game
package bomb_countdown_pkg;
  typedef enum logic [2:0] {
    GS_IDLE  = 3'b000,
    GS_START = 3'b001,
    GS_CLEAR = 3'b010,
    GS_FAIL  = 3'b011
  } game_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_RUN, PH_HOLD, PH_EXPIRED} phase_e;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] WRAP_9 = 4'd9;
  localparam logic [DIGIT_W-1:0] WRAP_5 = 4'd5;
  function automatic logic [7:0] sat8(input logic [9:0] v);
    return v > 10'd255 ? 8'hff : v[7:0];
  endfunction
endpackage

// File: rtl/bomb_countdown_if.sv
// bomb_countdown_if: game-side controls into the timer and the BCD time/status coming back
interface bomb_countdown_if;
  logic [2:0] i_State;
  logic       i_Sec1Tick;
  logic       i_Penalty;
  logic [3:0] o_Min10;
  logic [3:0] o_Min1;
  logic [3:0] o_Sec10;
  logic [3:0] o_Sec1;
  logic       o_TimeOut;
  logic       o_Warning;
  modport master (
    output i_State, i_Sec1Tick, i_Penalty,
    input  o_Min10, o_Min1, o_Sec10, o_Sec1, o_TimeOut, o_Warning
  );
  modport slave (
    input  i_State, i_Sec1Tick, i_Penalty,
    output o_Min10, o_Min1, o_Sec10, o_Sec1, o_TimeOut, o_Warning
  );
endinterface

// File: rtl/bomb_countdown_bcd_digit_down.sv
// bcd_digit_down: one BCD down-counting digit that wraps to WRAP and borrows from the next digit
module bcd_digit_down
  import bomb_countdown_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP = WRAP_9,
  parameter logic [DIGIT_W-1:0] INIT = '0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               load,
  input  logic               dec,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow
);
  assign borrow = dec && digit == '0;
  // load wins over dec; a zero digit wraps and passes the borrow on
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) digit <= INIT;
    else if (load) digit <= INIT;
    else if (dec) digit <= digit == '0 ? WRAP : digit - 1'b1;
endmodule

// File: rtl/bomb_countdown.sv
// bomb_countdown: MM:SS BCD countdown with tick/penalty draining, warning level and time-out pulse
module bomb_countdown
  import bomb_countdown_pkg::*;
#(
  parameter logic [7:0] P_INIT_MM = 8'h05,
  parameter logic [7:0] P_INIT_SS = 8'h00,
  parameter logic [7:0] P_WARN_SS = 8'h10,
  parameter logic [7:0] P_PENALTY = 8'd10
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  bomb_countdown_if.slave bus
);
  localparam logic [15:0] INIT = {P_INIT_MM, P_INIT_SS};
  phase_e      phase, phase_nxt;
  logic [7:0]  pending, pending_nxt;
  logic [3:0]  dig [4];
  logic [4:0]  chain;
  logic [15:0] time_now;
  logic [9:0]  sum;
  logic        run_go, dec, expire, timeout, warning, warn_nxt;
  assign time_now = {dig[3], dig[2], dig[1], dig[0]};
  assign run_go   = phase == PH_RUN && bus.i_State == GS_START;
  assign dec      = run_go && (bus.i_Sec1Tick || pending != 8'd0) && time_now != 16'h0000;
  assign expire   = dec && time_now == 16'h0001;
  assign chain[0] = dec;
  assign sum      = {2'b00, pending} + (bus.i_Penalty ? {2'b00, P_PENALTY} : 10'd0)
                  + {9'd0, bus.i_Sec1Tick} - {9'd0, dec};
  assign warn_nxt = phase == PH_RUN && time_now[15:8] == 8'h00 && time_now[7:0] <= P_WARN_SS;
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_dig
      bcd_digit_down #(
        .WRAP (i == 1 ? WRAP_5 : WRAP_9),
        .INIT (INIT[4*i +: 4])
      ) u_dig (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .load   (phase == PH_IDLE),
        .dec    (chain[i]),
        .digit  (dig[i]),
        .borrow (chain[i+1])
      );
    end
  endgenerate
  // dec is gated off at 00:00, so the top digit can never be asked to borrow
  always_comb assert (!chain[4]);
  // seconds still owed only accumulate while actually counting; any exit or expiry drops them
  always_comb pending_nxt = run_go && !expire ? sat8(sum) : 8'h00;
  // phase transitions; expiry takes priority over the game state leaving 001
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE:    phase_nxt = bus.i_State == GS_START ? PH_RUN : PH_IDLE;
      PH_RUN:     phase_nxt = expire ? PH_EXPIRED : bus.i_State == GS_START ? PH_RUN :
                              bus.i_State == GS_IDLE ? PH_IDLE : PH_HOLD;
      PH_HOLD:    phase_nxt = bus.i_State == GS_IDLE ? PH_IDLE :
                              bus.i_State == GS_START ? PH_RUN : PH_HOLD;
      PH_EXPIRED: phase_nxt = bus.i_State == GS_IDLE ? PH_IDLE : PH_EXPIRED;
      default:    phase_nxt = PH_IDLE;
    endcase
  end
  // state, pending count and registered status outputs
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      phase   <= PH_IDLE;
      pending <= 8'h00;
      timeout <= 1'b0;
      warning <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      pending <= pending_nxt;
      timeout <= expire;
      warning <= warn_nxt;
    end
  assign bus.o_Sec1    = dig[0];
  assign bus.o_Sec10   = dig[1];
  assign bus.o_Min1    = dig[2];
  assign bus.o_Min10   = dig[3];
  assign bus.o_TimeOut = timeout;
  assign bus.o_Warning = warning;
endmodule

// File: tb/tb_bomb_countdown.sv
// tb_bomb_countdown: directed vector table plus hand sequences on two timer instances (01:00 and 00:12)
module tb_bomb_countdown;
  typedef struct {
    logic [2:0]  st;
    logic        tick;
    logic        pen;
    logic [15:0] dig;
    logic        to;
    logic        warn;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [17];
  bomb_countdown_if ifa ();
  bomb_countdown_if ifb ();
  bomb_countdown #(.P_INIT_MM(8'h01), .P_INIT_SS(8'h00)) dut_a (.i_Clk(clk), .i_Rst(rst_n), .bus(ifa));
  bomb_countdown #(.P_INIT_MM(8'h00), .P_INIT_SS(8'h12)) dut_b (.i_Clk(clk), .i_Rst(rst_n), .bus(ifb));
  always #10 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction
  function automatic logic [15:0] dig_a();
    return {ifa.o_Min10, ifa.o_Min1, ifa.o_Sec10, ifa.o_Sec1};
  endfunction
  function automatic logic [15:0] dig_b();
    return {ifb.o_Min10, ifb.o_Min1, ifb.o_Sec10, ifb.o_Sec1};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc_a(input logic [2:0] st, input logic t, input logic p);
    ifa.i_State = st;
    ifa.i_Sec1Tick = t;
    ifa.i_Penalty = p;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc_b(input logic [2:0] st, input logic t, input logic p);
    ifb.i_State = st;
    ifb.i_Sec1Tick = t;
    ifb.i_Penalty = p;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0] = '{3'd1, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    for (int i = 1; i <= 12; i++) tbl[i] = '{3'd1, 1'b1, 1'b0, to_bcd(12 - i), i == 12, (13 - i) <= 10};
    tbl[13] = '{3'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[14] = '{3'd1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[16] = '{3'd0, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    ifa.i_State = 3'd0; ifa.i_Sec1Tick = 1'b0; ifa.i_Penalty = 1'b0;
    ifb.i_State = 3'd0; ifb.i_Sec1Tick = 1'b0; ifb.i_Penalty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_dig", dig_a(), 16'h0100);
    chk("rst_b_dig", dig_b(), 16'h0012);
    chk("rst_a_to", ifa.o_TimeOut, 0);
    chk("rst_a_warn", ifa.o_Warning, 0);
    chk("rst_a_pend", dut_a.pending, 0);
    rst_n = 1'b1;
    // 00:12 countdown to expiry, expired hold, reload
    for (int i = 0; i < 17; i++) begin
      cyc_b(tbl[i].st, tbl[i].tick, tbl[i].pen);
      chk($sformatf("b_dig[%0d]", i), dig_b(), tbl[i].dig);
      chk($sformatf("b_to[%0d]", i), ifb.o_TimeOut, tbl[i].to);
      chk($sformatf("b_warn[%0d]", i), ifb.o_Warning, tbl[i].warn);
    end
    // hold freezes digits, idle reloads, run resumes from preset
    cyc_b(3'd1, 1'b0, 1'b0);
    cyc_b(3'd1, 1'b1, 1'b0);
    chk("b_run_11", dig_b(), 16'h0011);
    cyc_b(3'd2, 1'b1, 1'b0);
    chk("b_leave_tick", dig_b(), 16'h0011);
    for (int k = 0; k < 5; k++) cyc_b(k[0] ? 3'b101 : 3'b010, 1'b1, 1'b1);
    chk("b_hold_dig", dig_b(), 16'h0011);
    chk("b_hold_pend", dut_b.pending, 0);
    cyc_b(3'd1, 1'b1, 1'b0);
    chk("b_resume_edge", dig_b(), 16'h0011);
    cyc_b(3'd1, 1'b1, 1'b0);
    chk("b_resume_dec", dig_b(), 16'h0010);
    cyc_b(3'd2, 1'b0, 1'b0);
    cyc_b(3'd0, 1'b0, 1'b0);
    chk("b_idle_entry", dig_b(), 16'h0010);
    cyc_b(3'd0, 1'b0, 1'b0);
    chk("b_reload", dig_b(), 16'h0012);
    cyc_b(3'd1, 1'b0, 1'b0);
    cyc_b(3'd1, 1'b1, 1'b0);
    chk("b_restart", dig_b(), 16'h0011);
    ifb.i_State = 3'd0; ifb.i_Sec1Tick = 1'b0;
    // 01:00 borrow across all digits
    cyc_a(3'd1, 1'b0, 1'b0);
    chk("a_load", dig_a(), 16'h0100);
    cyc_a(3'd1, 1'b1, 1'b0);
    chk("a_borrow", dig_a(), 16'h0059);
    for (int k = 0; k < 29; k++) cyc_a(3'd1, 1'b1, 1'b0);
    chk("a_at30", dig_a(), 16'h0030);
    // penalty drains one second per clock after passing through pending
    cyc_a(3'd1, 1'b0, 1'b1);
    chk("a_pen_dig", dig_a(), 16'h0030);
    chk("a_pen_pend", dut_a.pending, 10);
    for (int k = 1; k <= 10; k++) begin
      cyc_a(3'd1, 1'b0, 1'b0);
      chk($sformatf("a_drain[%0d]", k), dig_a(), to_bcd(30 - k));
    end
    cyc_a(3'd1, 1'b0, 1'b0);
    chk("a_drain_end", dig_a(), 16'h0020);
    chk("a_drain_pend", dut_a.pending, 0);
    // a tick during the drain adds one more second
    cyc_a(3'd1, 1'b0, 1'b1);
    cyc_a(3'd1, 1'b0, 1'b0);
    chk("a_d2_first", dig_a(), 16'h0019);
    cyc_a(3'd1, 1'b1, 1'b0);
    chk("a_d2_tick", dig_a(), 16'h0018);
    chk("a_d2_pend", dut_a.pending, 9);
    chk("a_d2_warn", ifa.o_Warning, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc_a(3'd1, 1'b0, 1'b0);
      chk($sformatf("a_d2_dig[%0d]", k), dig_a(), to_bcd(18 - k));
      chk($sformatf("a_d2_warn[%0d]", k), ifa.o_Warning, (19 - k) <= 10);
    end
    chk("a_d2_pend_end", dut_a.pending, 0);
    // penalty larger than the remaining time stops at 00:00 with one pulse
    cyc_a(3'd1, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cyc_a(3'd1, 1'b0, 1'b0);
      chk($sformatf("a_over_dig[%0d]", k), dig_a(), to_bcd(9 - k));
      chk($sformatf("a_over_to[%0d]", k), ifa.o_TimeOut, k == 9);
    end
    chk("a_over_pend", dut_a.pending, 0);
    cyc_a(3'd1, 1'b1, 1'b0);
    chk("a_exp_dig", dig_a(), 16'h0000);
    chk("a_exp_to", ifa.o_TimeOut, 0);
    chk("a_exp_warn", ifa.o_Warning, 0);
    // asynchronous reset in the middle of a drain
    cyc_a(3'd0, 1'b0, 1'b0);
    cyc_a(3'd0, 1'b0, 1'b0);
    chk("a_reload", dig_a(), 16'h0100);
    cyc_a(3'd1, 1'b0, 1'b0);
    for (int k = 0; k < 51; k++) cyc_a(3'd1, 1'b1, 1'b0);
    chk("a_at09", dig_a(), 16'h0009);
    cyc_a(3'd1, 1'b0, 1'b1);
    cyc_a(3'd1, 1'b0, 1'b0);
    cyc_a(3'd1, 1'b0, 1'b0);
    chk("a_mid_dig", dig_a(), 16'h0007);
    chk("a_mid_pend", dut_a.pending, 8);
    chk("a_mid_warn", ifa.o_Warning, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("a_arst_dig", dig_a(), 16'h0100);
    chk("a_arst_to", ifa.o_TimeOut, 0);
    chk("a_arst_warn", ifa.o_Warning, 0);
    chk("a_arst_pend", dut_a.pending, 0);
    ifa.i_State = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_a(3'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
